// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer.
//   INST_W        : instruction word width.
//   DEF_RESET_VEC : default PC loaded on reset.
//   DEF_TRAP_VEC  : default target for traps and misaligned redirects.
//   state_t       : sequencer FSM state encoding.
package pc_seq_pkg;

    localparam int          INST_W        = 32;
    localparam logic [63:0] DEF_RESET_VEC = 64'h0;
    localparam logic [63:0] DEF_TRAP_VEC  = 64'h100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder built from 4-bit carry-lookahead blocks; the block
// carries ripple between blocks. There is no carry-out, so additions
// wrap modulo 2^WIDTH.
// Ports:
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, truncated to WIDTH bits
// WIDTH must be a multiple of 4.
module carry_lookahead_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    localparam int NB = WIDTH / 4;

    // The top generate bit is never needed: nothing consumes carry-out.
    logic [WIDTH-2:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;

    assign g    = a[WIDTH-2:0] & b[WIDTH-2:0];
    assign p    = a ^ b;
    assign c[0] = cin;

    for (genvar blk = 0; blk < NB; blk++) begin : g_blk
        localparam int B = blk * 4;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        if (blk < NB - 1) begin : g_bout
            // Block generate/propagate feed the next block's carry-in.
            logic gg, pp;
            assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign pp = &p[B+3:B];
            assign c[B+4] = gg | (pp & c[B]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer.
// Issues fetch requests at pc, registers the returned instruction, steps
// pc by 4, and handles branch redirects, traps, stalls and flushes of an
// in-flight fetch whose result must be dropped.
// Ports:
//   clk, reset        : clock (rising edge), async active-high reset
//   stall             : hold fetch after the current handshake completes
//   redirect_valid    : branch/jump redirect, target in redirect_target
//   trap              : redirect to TRAP_VEC, outranks redirect_valid
//   fetch_req/addr    : fetch request and its address (= pc)
//   fetch_ack/data    : fetch completion and returned instruction
//   inst_valid        : one-cycle pulse, inst_out/inst_pc valid
//   inst_out, inst_pc : registered instruction and its address
//   misalign          : one-cycle pulse for a redirect to a non-word address
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int           n         = 64,
    parameter logic [n-1:0] RESET_VEC = n'(DEF_RESET_VEC),
    parameter logic [n-1:0] TRAP_VEC  = n'(DEF_TRAP_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [n-1:0]      redirect_target,
    input  logic              trap,
    output logic              fetch_req,
    output logic [n-1:0]      fetch_addr,
    input  logic              fetch_ack,
    input  logic [INST_W-1:0] fetch_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [n-1:0]      inst_pc,
    output logic              misalign
);

    localparam logic [n-1:0] PC_STEP = n'(4);

    state_t       state, state_nxt;
    logic [n-1:0] pc, pc_inc, tgt;
    logic         redir, rt_mis, mis_evt;
    logic [n-1:0] eff;

    // Effective redirect target: traps and misaligned targets both land
    // on TRAP_VEC; only the misaligned (non-trap) case raises misalign.
    assign redir   = trap | redirect_valid;
    assign rt_mis  = redirect_target[1:0] != 2'b00;
    assign eff     = (trap || rt_mis) ? TRAP_VEC : redirect_target;
    assign mis_evt = redirect_valid & ~trap & rt_mis;

    carry_lookahead_adder #(n) u_inc (
        .a   (pc),
        .b   (PC_STEP),
        .cin (1'b0),
        .sum (pc_inc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    // Next-state logic. stall is only sampled when a handshake completes.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (fetch_ack)  state_nxt = stall ? STALL : FETCH;
                else if (redir) state_nxt = FLUSH;
            end
            FLUSH: if (fetch_ack) state_nxt = stall ? STALL : FETCH;
            STALL: if (!stall)    state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // Outputs decoded from registered state/pc only.
    always_comb begin
        fetch_req = 1'b0;
        case (state)
            FETCH, FLUSH: fetch_req = 1'b1;
            default:      fetch_req = 1'b0;
        endcase
    end

    assign fetch_addr = pc;

    // Datapath: pc, latched flush target and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_VEC;
            tgt        <= '0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            misalign   <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                FETCH: begin
                    misalign <= mis_evt;
                    if (fetch_ack) begin
                        if (redir) begin
                            pc <= eff;            // drop the fetched word
                        end else begin
                            inst_valid <= 1'b1;
                            inst_out   <= fetch_data;
                            inst_pc    <= pc;
                            pc         <= pc_inc;
                        end
                    end else if (redir) begin
                        // Request stays outstanding; remember where to go.
                        tgt <= eff;
                    end
                end
                FLUSH: begin
                    misalign <= mis_evt;
                    if (fetch_ack) pc  <= redir ? eff : tgt;
                    else if (redir) tgt <= eff;
                end
                STALL: begin
                    misalign <= mis_evt;
                    if (redir) pc <= eff;
                end
                default: ;  // BOOT ignores acks and redirects
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of per-cycle vectors followed
// by hand-written async-reset sequences.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        trap = 1'b0;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.n(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .fetch_data      (fetch_data),
        .inst_valid      (inst_valid),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .misalign        (misalign)
    );

    typedef struct {
        logic        st, rv, tr, ak;
        logic [63:0] rt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [63:0] e_ipc;
        logic        e_mis;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, rv, tr, ak, input logic [63:0] rt,
                                input logic er, input logic [63:0] ea,
                                input logic eiv, input logic [63:0] eipc, input logic emis);
        vec_t v;
        v.st = st; v.rv = rv; v.tr = tr; v.ak = ak; v.rt = rt;
        v.e_req = er; v.e_addr = ea; v.e_iv = eiv; v.e_ipc = eipc; v.e_mis = emis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        //              st rv tr ak  rt              req addr            iv ipc             mis
        vecs[0]  = mk(0, 0, 0, 0, 64'h0,          0, 64'h0,            0, 64'h0,            0); // BOOT
        vecs[1]  = mk(0, 0, 0, 1, 64'h0,          1, 64'h0,            1, 64'h0,            0);
        vecs[2]  = mk(0, 0, 0, 1, 64'h0,          1, 64'h4,            1, 64'h4,            0);
        vecs[3]  = mk(0, 0, 0, 1, 64'h0,          1, 64'h8,            1, 64'h8,            0);
        vecs[4]  = mk(0, 0, 0, 0, 64'h0,          1, 64'hc,            0, 64'h0,            0); // ack delayed
        vecs[5]  = mk(0, 0, 0, 0, 64'h0,          1, 64'hc,            0, 64'h0,            0);
        vecs[6]  = mk(0, 0, 0, 0, 64'h0,          1, 64'hc,            0, 64'h0,            0);
        vecs[7]  = mk(0, 0, 0, 1, 64'h0,          1, 64'hc,            1, 64'hc,            0);
        vecs[8]  = mk(0, 1, 0, 0, 64'h40,         1, 64'h10,           0, 64'h0,            0); // -> FLUSH
        vecs[9]  = mk(0, 0, 0, 0, 64'h0,          1, 64'h10,           0, 64'h0,            0);
        vecs[10] = mk(0, 0, 0, 1, 64'h0,          1, 64'h10,           0, 64'h0,            0); // dropped
        vecs[11] = mk(0, 0, 0, 1, 64'h0,          1, 64'h40,           1, 64'h40,           0);
        vecs[12] = mk(0, 1, 1, 1, 64'h80,         1, 64'h44,           0, 64'h0,            0); // trap wins
        vecs[13] = mk(0, 1, 0, 1, 64'h42,         1, 64'h100,          0, 64'h0,            1); // misaligned
        vecs[14] = mk(0, 0, 0, 1, 64'h0,          1, 64'h100,          1, 64'h100,          0);
        vecs[15] = mk(1, 0, 0, 1, 64'h0,          1, 64'h104,          1, 64'h104,          0); // -> STALL
        vecs[16] = mk(1, 0, 0, 1, 64'h0,          0, 64'h108,          0, 64'h0,            0); // ack ignored
        vecs[17] = mk(1, 1, 0, 0, 64'h200,        0, 64'h108,          0, 64'h0,            0);
        vecs[18] = mk(0, 0, 0, 0, 64'h0,          0, 64'h200,          0, 64'h0,            0);
        vecs[19] = mk(0, 0, 0, 1, 64'h0,          1, 64'h200,          1, 64'h200,          0);
        vecs[20] = mk(0, 1, 0, 0, 64'h300,        1, 64'h204,          0, 64'h0,            0); // -> FLUSH
        vecs[21] = mk(0, 1, 0, 0, 64'h400,        1, 64'h204,          0, 64'h0,            0); // overwrite
        vecs[22] = mk(0, 0, 0, 1, 64'h0,          1, 64'h204,          0, 64'h0,            0);
        vecs[23] = mk(0, 0, 0, 1, 64'h0,          1, 64'h400,          1, 64'h400,          0);
        vecs[24] = mk(0, 1, 0, 1, 64'hffff_ffff_ffff_fffc, 1, 64'h404, 0, 64'h0,            0);
        vecs[25] = mk(0, 0, 0, 1, 64'h0,          1, 64'hffff_ffff_ffff_fffc, 1, 64'hffff_ffff_ffff_fffc, 0);
        vecs[26] = mk(0, 0, 0, 1, 64'h0,          1, 64'h0,            1, 64'h0,            0); // wrapped
        vecs[27] = mk(0, 0, 0, 0, 64'h0,          1, 64'h4,            0, 64'h0,            0);

        // Async reset: outputs must clear before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_req",  fetch_req,  0);
        chk("rst_addr", fetch_addr, 0);
        chk("rst_iv",   inst_valid, 0);
        chk("rst_inst", inst_out,   0);
        chk("rst_ipc",  inst_pc,    0);
        chk("rst_mis",  misalign,   0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall           = vecs[i].st;
            redirect_valid  = vecs[i].rv;
            trap            = vecs[i].tr;
            fetch_ack       = vecs[i].ak;
            redirect_target = vecs[i].rt;
            fetch_data      = 32'hc0de_0000 | 32'(i);
            #1;
            chk($sformatf("v%0d_req", i),  fetch_req,  vecs[i].e_req);
            chk($sformatf("v%0d_addr", i), fetch_addr, vecs[i].e_addr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_iv", i),  inst_valid, vecs[i].e_iv);
            chk($sformatf("v%0d_mis", i), misalign,   vecs[i].e_mis);
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_ipc", i),  inst_pc,  vecs[i].e_ipc);
                chk($sformatf("v%0d_inst", i), inst_out, 64'(32'hc0de_0000 | 32'(i)));
            end
        end

        // Reset mid-request: request drops at once, pc back to RESET_VEC.
        stall = 0; redirect_valid = 0; trap = 0; fetch_ack = 0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req",  fetch_req,  0);
        chk("mid_rst_addr", fetch_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        // A stale ack arriving during BOOT must be ignored.
        fetch_ack  = 1'b1;
        fetch_data = 32'hbad0_bad0;
        #1;
        chk("boot_req", fetch_req, 0);
        @(posedge clk); #1;
        chk("boot_iv", inst_valid, 0);
        fetch_data = 32'h1234_5678;
        #1;
        chk("post_req",  fetch_req,  1);
        chk("post_addr", fetch_addr, 0);
        @(posedge clk); #1;
        chk("post_iv",   inst_valid, 1);
        chk("post_ipc",  inst_pc,    0);
        chk("post_inst", inst_out,   64'h1234_5678);
        fetch_ack = 1'b0;
        #1;
        chk("post_addr2", fetch_addr, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter n, 64, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, 0, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VEC, 'h100, redirect target on trap or misaligned target.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold fetch after the current handshake completes.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_target  in  n  redirect address.
- trap  in  1  redirect to TRAP_VEC; outranks redirect_valid.
- fetch_req  out  1  instruction fetch request.
- fetch_addr  out  n  fetch address; equals pc.
- fetch_ack  in  1  fetch completes this cycle; fetch_data valid.
- fetch_data  in  32  fetched instruction.
- inst_valid  out  1  one-cycle pulse: inst_out/inst_pc valid.
- inst_out  out  32  registered instruction.
- inst_pc  out  n  address of inst_out.
- misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0.

Function
REQ-005 SHALL implement FSM states BOOT, FETCH, STALL, FLUSH; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-006 SHALL drive fetch_req=1 in FETCH and FLUSH, 0 in BOOT and STALL; fetch_addr SHALL hold pc stable while fetch_req=1 and fetch_ack=0.
REQ-007 FETCH with fetch_ack and no redirect/trap SHALL next cycle pulse inst_valid with inst_out=fetch_data and inst_pc=pc (latency 1), and set pc<=pc+4.
REQ-008 pc+4 SHALL wrap modulo 2^n (2^n-4 -> 0).
REQ-009 Effective target SHALL be TRAP_VEC if trap=1; otherwise redirect_target, replaced by TRAP_VEC with misalign pulsed next cycle when redirect_target[1:0] != 0.
REQ-010 Redirect/trap in FETCH with fetch_ack SHALL discard fetch_data (no inst_valid), set pc<=effective target, remain FETCH (or STALL if stall=1).
REQ-011 Redirect/trap in FETCH without fetch_ack SHALL latch effective target and enter FLUSH; the outstanding request SHALL NOT be withdrawn.
REQ-012 In FLUSH, a newer redirect/trap SHALL overwrite the latched target; on fetch_ack the data SHALL be discarded, pc<=latched target (or the same-cycle redirect/trap target if present), then FETCH (or STALL if stall=1).
REQ-013 stall SHALL take effect only at handshake completion: FETCH with fetch_ack and stall=1 accepts the instruction and enters STALL; stall without fetch_ack keeps requesting.
REQ-014 In STALL, pc SHALL hold; redirect/trap SHALL update pc immediately without leaving STALL; stall=0 SHALL return to FETCH next cycle.
REQ-015 fetch_ack outside FETCH/FLUSH SHALL be ignored.
REQ-016 inst_valid and misalign SHALL be single-cycle pulses, 0 otherwise.

Reset
REQ-017 On reset assertion, without waiting for clk: pc=RESET_VEC, state=BOOT, fetch_req=0, inst_valid=0, inst_out=0, inst_pc=0, misalign=0, latched target=0.
REQ-018 Reset mid-handshake SHALL abandon the request; any later fetch_ack for it SHALL be ignored via BOOT.

Structure
REQ-019 State encoding, instruction width (32), and default RESET_VEC/TRAP_VEC SHALL reside in shared package pc_seq_pkg.
REQ-020 pc+4 SHALL be computed by one instance of the existing carry_lookahead_adder #(n); no other sub-modules.
REQ-021 All state, pc, and outputs except fetch_req/fetch_addr SHALL be registered; fetch_req/fetch_addr SHALL decode from registered state/pc only.

Verification
REQ-022 Reset, ack every cycle from cycle 2 -> fetch_addr 0,4,8,12; inst_valid pulses with inst_pc 0,4,8.
REQ-023 Ack delayed 3 cycles at pc=8 -> fetch_addr holds 8 for 3 cycles, then single inst_valid with inst_pc=8, next fetch_addr=12.
REQ-024 redirect_valid, target 'h40, without ack at pc=4; ack 2 cycles later -> FLUSH, no inst_valid for pc 4, next fetch_addr='h40.
REQ-025 trap=1 and redirect_valid target 'h80 same cycle as ack -> pc='h100, no inst_valid; redirect target 'h42 -> misalign pulse, pc='h100.
REQ-026 stall=1 with ack at pc=8 -> inst_pc=8 delivered, fetch_req=0 while stalled, resume at fetch_addr=12; reset asserted mid-request -> fetch_req=0 immediately, pc=0.
REQ-027 pc preset near wrap via redirect to 2^64-4, acked -> next fetch_addr=0.
